// File: rtl/fa_pattern_applier.sv
// rtl/fa_pattern_applier.sv - applies test patterns to a 4-bit adder, samples and grades its response
module fa_pattern_applier #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [3:0]       pat_a,
  input  logic [3:0]       pat_b,
  input  logic             pat_cin,
  input  logic [4:0]       pat_exp,
  output logic [3:0]       dut_a,
  output logic [3:0]       dut_b,
  output logic             dut_cin,
  input  logic [4:0]       dut_resp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic [4:0]       res_obs,
  output logic [CNT_W-1:0] pat_count,
  output logic [CNT_W-1:0] fail_count
);

  // Settle counter only needs to hold SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] APPLY  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0]    state;
  logic [4:0]    exp_q;
  logic [SW-1:0] settle;
  logic          accept;
  logic          sample;
  logic          mismatch;

  assign accept   = (state == IDLE) && pat_valid && pat_ready;
  assign sample   = (state == APPLY) && (settle == '0);
  assign mismatch = (dut_resp != exp_q);

  // Control FSM; pat_ready and res_valid are registered so they are clean after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_ready <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= APPLY;
            pat_ready <= 1'b0;
          end else begin
            pat_ready <= 1'b1;
          end
        end
        APPLY: begin
          if (sample) begin
            state     <= REPORT;
            res_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            pat_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pat_ready <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Drive the adder, time the settle window, and capture the graded response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a    <= 4'd0;
      dut_b    <= 4'd0;
      dut_cin  <= 1'b0;
      exp_q    <= 5'd0;
      settle   <= '0;
      res_obs  <= 5'd0;
      res_pass <= 1'b0;
    end else begin
      if (accept) begin
        dut_a   <= pat_a;
        dut_b   <= pat_b;
        dut_cin <= pat_cin;
        exp_q   <= pat_exp;
        settle  <= SETTLE_LOAD;
      end else if (state == APPLY && !sample) begin
        settle <= settle - 1'b1;
      end
      if (sample) begin
        res_obs  <= dut_resp;
        res_pass <= !mismatch;
      end
    end
  end

  // Saturating pattern/fail counters; clr wins over a same-edge increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_count  <= '0;
      fail_count <= '0;
    end else if (clr) begin
      pat_count  <= '0;
      fail_count <= '0;
    end else if (sample) begin
      if (pat_count != '1) pat_count <= pat_count + 1'b1;
      if (mismatch && fail_count != '1) fail_count <= fail_count + 1'b1;
    end
  end

endmodule

// File: doc/fa_pattern_applier.md
Name: fa_pattern_applier

Overview:
- Sequential test-application stage wrapped around the 4-bit ripple-carry full-adder benchmark (the DUT).
- Upstream side: accepts test patterns over a valid/ready stream, each pattern being a, b, cin plus the expected {cout,s3..s0}.
- DUT side: drives the adder's a/b/cin inputs and holds them stable for a settle window, then samples the adder's 5 outputs.
- Downstream side: compares the sample against the expected value and reports pass/fail with observed response and running counts. This is the pattern-apply/response-capture stage for PODEM-generated vectors.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between driving DUT inputs and sampling DUT outputs; legal range >= 1.
- CNT_W, 16, width of the pattern and fail counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of pat_count and fail_count.
- pat_valid  input  1  pattern offered.
- pat_ready  output  1  applier can accept a pattern.
- pat_a  input  4  operand A.
- pat_b  input  4  operand B.
- pat_cin  input  1  carry in.
- pat_exp  input  5  expected response {cout,s3,s2,s1,s0}.
- dut_a  output  4  to adder a3..a0.
- dut_b  output  4  to adder b3..b0.
- dut_cin  output  1  to adder cin.
- dut_resp  input  5  from adder {cout,s3,s2,s1,s0}.
- res_valid  output  1  result available.
- res_ready  input  1  downstream accepts result.
- res_pass  output  1  1 when the sampled response equals pat_exp.
- res_obs  output  5  sampled dut_resp.
- pat_count  output  CNT_W  patterns completed.
- fail_count  output  CNT_W  patterns failed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - pat_ready=0 while rst_n is low, then 1 from the first clk edge after release.
  - res_valid=0, res_pass=0, res_obs=0, dut_a=0, dut_b=0, dut_cin=0, pat_count=0, fail_count=0, expected register=0, settle counter=0.
- FSM states: IDLE, APPLY, REPORT.
- IDLE:
  - pat_ready=1.
  - Accept on a clk edge with pat_valid&pat_ready: register pat_a/pat_b/pat_cin onto dut_*, register pat_exp, load settle counter with SETTLE_CYCLES-1, go to APPLY.
- APPLY:
  - pat_ready=0; dut_* held constant.
  - Counter decrements each edge. On the edge where the counter is 0:
    - res_obs<=dut_resp.
    - res_pass<=(dut_resp==exp).
    - pat_count increments; fail_count increments if mismatch.
    - Go to REPORT.
- REPORT:
  - res_valid=1; res_obs and res_pass are stable.
  - On an edge with res_ready: res_valid drops and state goes to IDLE.
- Latency:
  - Accept edge E0 to sample edge E0+SETTLE_CYCLES.
  - res_valid is high immediately after the sample edge.
  - Minimum pattern period is SETTLE_CYCLES+2 cycles, because pat_ready is low in APPLY and REPORT (one-cycle bubble in IDLE).
- dut_* hold the last applied pattern after completion and change only on the next accept. The DUT sees no glitch between patterns.
- Comparison is exact over all 5 bits; there are no don't-care bits.
- Counters saturate at all-ones and do not wrap.
- clr:
  - clr=1 zeroes both counters on that edge and takes priority over a simultaneous increment.
  - clr does not affect the FSM, dut_*, or res_*.
- pat_valid is ignored outside IDLE. Pattern inputs need not be held after the accept edge.
- res_ready while res_valid=0 has no effect.
- Reset mid-operation (APPLY or REPORT) abandons the pattern. No count is recorded and all outputs take their reset values.

Test Plan:
- Reset/idle: hold rst_n=0 → all outputs 0; release rst_n → pat_ready=1 after the first clk edge; no res_valid with pat_valid=0.
- Pass vector: a=5, b=3, cin=0, exp=5'b01000 with the adder connected → res_valid exactly 2 cycles after accept, res_obs=01000, res_pass=1, pat_count=1, fail_count=0.
- Carry boundaries:
  - a=F, b=1, cin=0, exp=10000 → pass.
  - a=F, b=F, cin=1, exp=11111 → pass.
  - a=0, b=0, cin=0, exp=00000 → pass.
  - Final state: pat_count=3, fail_count=0.
- Injected fault: force adder output s1 stuck-at-0, apply a=1, b=1, cin=0, exp=00010 → res_obs=00000, res_pass=0, fail_count=1. Hold res_ready=0 for 5 cycles → res_valid stays 1, pat_ready stays 0, pattern accepted on dut_* unchanged.
- Counter controls:
  - CNT_W=2: run 5 patterns → pat_count saturates at 3.
  - Assert clr on the same edge as a sample → both counters read 0 afterwards.
- Reset mid-APPLY with SETTLE_CYCLES=4: drop rst_n one cycle after accept → dut_*=0, pat_count=0, res_valid never asserts for that pattern; the next pattern after release completes normally.
